// File: rtl/gpio_in_multi_pkg.sv
// Shared definitions for the multi-channel GPIO input block: register offsets, bit positions, sync depth.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package gpio_in_multi_pkg;

  // Register select offsets within a channel's 4-register window
  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_MODE   = 2'd2;

  // STATUS bit positions
  localparam int STATUS_FRESH_BIT   = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  // MODE bit positions
  localparam int MODE_SAMPLE_BIT = 0;
  localparam int MODE_BLOCK_BIT  = 1;
  localparam int MODE_IE_BIT     = 2;

  // Number of flops between port_in and the sample-mode compare
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic overrun;
    logic fresh;
  } status_t;

  typedef struct packed {
    logic ie;
    logic block;
    logic sample;
  } mode_t;

  // Zero-extend STATUS to a bus byte
  function automatic logic [7:0] status_byte(input status_t s);
    return {6'b0, s};
  endfunction

  // Zero-extend MODE to a bus byte
  function automatic logic [7:0] mode_byte(input mode_t m);
    return {5'b0, m};
  endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One input channel: synchroniser, DATA/STATUS/MODE registers, capture and overrun logic.
// Latency: strobe capture visible after 1 edge; sample-mode change reaches FRESH after 3 edges.
// Backpressure: none; captures are never refused, an unread capture is flagged as OVERRUN.
module gpio_in_chan
  import gpio_in_multi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_in,
  input  logic       port_write,
  input  logic       wr_hit,     // bus write addressed to this channel
  input  logic [1:0] sel,
  input  logic [7:0] wr_data,
  input  logic       rd_take,    // accepted DATA read of this channel
  output logic [7:0] data,
  output status_t    status,
  output mode_t      mode
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] synced;
  logic       capture;
  logic       cap_set;
  logic [7:0] cap_val;
  logic       data_wr;
  logic       status_wr;
  logic       mode_wr;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign data_wr   = wr_hit & (sel == SEL_DATA);
  assign status_wr = wr_hit & (sel == SEL_STATUS);
  assign mode_wr   = wr_hit & (sel == SEL_MODE);

  // Sample mode captures on any difference against DATA; strobe mode on port_write.
  // A simultaneous bus DATA write overrides the capture entirely, status included.
  assign capture = mode.sample ? (synced != data) : port_write;
  assign cap_set = capture & ~data_wr;
  assign cap_val = mode.sample ? synced : port_in;

  // Synchroniser runs regardless of mode so switching to SAMPLE sees settled data
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], port_in};
    end
  end

  // DATA/STATUS/MODE update; captures win over clears, bus DATA write wins over capture
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= '0;
      status <= '0;
      mode   <= '0;
    end else begin
      if (data_wr) begin
        data <= wr_data;
      end else if (cap_set) begin
        data <= cap_val;
      end

      if (cap_set && status.fresh) begin
        status.overrun <= 1'b1;
      end else if (status_wr && wr_data[STATUS_OVERRUN_BIT]) begin
        status.overrun <= 1'b0;
      end

      if (cap_set) begin
        status.fresh <= 1'b1;
      end else if (rd_take || (status_wr && wr_data[STATUS_FRESH_BIT])) begin
        status.fresh <= 1'b0;
      end

      if (mode_wr) begin
        mode.sample <= wr_data[MODE_SAMPLE_BIT];
        mode.block  <= wr_data[MODE_BLOCK_BIT];
        mode.ie     <= wr_data[MODE_IE_BIT];
      end
    end
  end

endmodule

// File: rtl/gpio_in_multi.sv
// Multi-channel GPIO input peripheral on a byte-wide bus: decode, read mux, handshake, irq.
// Latency: read data and ready_r one cycle after acceptance; ready_w one cycle after write.
// Backpressure: a DATA read of a BLOCK channel is held off (ready_r low) until FRESH is set.
module gpio_in_multi
  import gpio_in_multi_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  ready_r,
  output logic                  ready_w,
  input  logic [CHANNELS-1:0]   port_write,
  input  logic [CHANNELS*8-1:0] port_in,
  output logic                  irq
);

  localparam int CW = ADDR_W - 2;

  logic [CW-1:0]              chan_idx;
  logic [1:0]                 sel;
  logic [CHANNELS-1:0]        hit;
  logic [CHANNELS-1:0]        irq_src;
  logic [CHANNELS-1:0][7:0]   ch_data;
  status_t [CHANNELS-1:0]     ch_status;
  mode_t   [CHANNELS-1:0]     ch_mode;
  logic [7:0]                 rd_mux;
  logic                       sel_block;
  logic                       sel_fresh;
  logic                       rd_accept;

  assign chan_idx = address[ADDR_W-1:2];
  assign sel      = address[1:0];

  // Out-of-range channel indices match no hit bit, so they read 0 and drop writes
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [CW-1:0] IDX = CW'(i);

    assign hit[i]     = (chan_idx == IDX);
    assign irq_src[i] = ch_status[i].fresh & ch_mode[i].ie;

    gpio_in_chan u_chan (
      .clk        (clk),
      .reset      (reset),
      .port_in    (port_in[i*8 +: 8]),
      .port_write (port_write[i]),
      .wr_hit     (write & hit[i]),
      .sel        (sel),
      .wr_data    (data_in),
      .rd_take    (rd_accept & hit[i] & (sel == SEL_DATA)),
      .data       (ch_data[i]),
      .status     (ch_status[i]),
      .mode       (ch_mode[i])
    );
  end

  // Read mux plus the addressed channel's BLOCK/FRESH for the stall decision
  always_comb begin
    rd_mux    = '0;
    sel_block = 1'b0;
    sel_fresh = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (hit[i]) begin
        sel_block = ch_mode[i].block;
        sel_fresh = ch_status[i].fresh;
        case (sel)
          SEL_DATA:   rd_mux = ch_data[i];
          SEL_STATUS: rd_mux = status_byte(ch_status[i]);
          SEL_MODE:   rd_mux = mode_byte(ch_mode[i]);
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  // ~ready_r keeps a held read from being accepted twice back-to-back
  assign rd_accept = read & ~ready_r & ((sel != SEL_DATA) | ~sel_block | sel_fresh);

  // Registered bus responses and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      ready_r  <= 1'b0;
      ready_w  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ready_r <= rd_accept;
      ready_w <= write;
      irq     <= |irq_src;
      if (rd_accept) begin
        data_out <= rd_mux;
      end
    end
  end

endmodule
